count7_decoder: RTL and testbench

Receiving end of the `count7` colour-light interface. It samples the 3-bit code `{a2,a1,a0}` and the wrap strobe `gene` and checks that they follow the mod-7 sequence 0→1→…→6→0. While locked it decodes the code into an RGB lamp colour with PWM dimming, and it reports sequence violations. It sits directly downstream of `count7` in the ColorLight design, on the same clock.

---
 rtl/count7_pkg.sv | 18 +
 rtl/count7_decoder_if.sv | 25 ++
 rtl/pwm_gen.sv | 41 ++++
 rtl/count7_decoder.sv | 128 ++++++++++++
 tb/tb_count7_decoder.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/count7_pkg.sv
// Shared types and helpers for the count7 colour-light interface.
package count7_pkg;

    localparam int unsigned CODE_W = 3;
    localparam logic [CODE_W-1:0] CODE_MAX     = 3'd6;
    localparam logic [CODE_W-1:0] CODE_ILLEGAL = 3'd7;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

    // Lamp colour {r,g,b} for a code: code+1 in binary (0 -> blue, 6 -> white).
    function automatic logic [2:0] colour_of(input logic [CODE_W-1:0] code);
        return 3'(code + 3'd1);
    endfunction

endpackage

// File: rtl/count7_decoder_if.sv
// Bus between the count7 sequencer (master) and its decoder (slave).
interface count7_decoder_if #(
    parameter int unsigned ERR_W = 8
);
    logic             gene;
    logic             a0;
    logic             a1;
    logic             a2;
    logic             led_r;
    logic             led_g;
    logic             led_b;
    logic             locked;
    logic             seq_err;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output gene, a0, a1, a2,
        input  led_r, led_g, led_b, locked, seq_err, err_cnt
    );

    modport slave (
        input  gene, a0, a1, a2,
        output led_r, led_g, led_b, locked, seq_err, err_cnt
    );
endinterface

// File: rtl/pwm_gen.sv
// Free-running PWM: pwm_on is high for DUTY out of every 2^PWM_BITS cycles.
module pwm_gen #(
    parameter int unsigned PWM_BITS = 4,
    parameter int unsigned DUTY     = 16
) (
    input  logic clk,
    input  logic rst,
    output logic pwm_on
);

    localparam int unsigned PERIOD = 2 ** PWM_BITS;

    logic [PWM_BITS-1:0] r_cnt;
    logic                r_on;
    logic                w_on;

    // Duty extremes resolved at elaboration so the compare is never constant.
    generate
        if (DUTY == 0) begin : g_off
            assign w_on = 1'b0;
        end else if (DUTY >= PERIOD) begin : g_on
            assign w_on = 1'b1;
        end else begin : g_cmp
            assign w_on = (r_cnt < PWM_BITS'(DUTY));
        end
    endgenerate

    // Period counter and registered enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_on  <= 1'b0;
        end else begin
            r_cnt <= r_cnt + PWM_BITS'(1);
            r_on  <= w_on;
        end
    end

    assign pwm_on = r_on;

endmodule

// File: rtl/count7_decoder.sv
// Checks the mod-7 code sequence from count7 and drives the dimmed RGB lamp.
module count7_decoder
    import count7_pkg::*;
#(
    parameter int unsigned PWM_BITS = 4,
    parameter int unsigned DUTY     = 16,
    parameter int unsigned ERR_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    count7_decoder_if.slave   bus
);

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic [CODE_W-1:0] r_code_q;
    logic [CODE_W-1:0] r_code_p;
    logic              r_gene_q;
    state_e            r_state;
    logic              r_locked;
    logic              r_seq_err;
    logic [ERR_W-1:0]  r_err_cnt;
    logic [2:0]        r_rgb;

    logic              w_pwm_on;
    logic              w_hold;
    logic              w_step;
    logic              w_wrap;
    logic              w_legal;
    logic              w_lock_req;
    logic              w_locked_next;

    pwm_gen #(
        .PWM_BITS (PWM_BITS),
        .DUTY     (DUTY)
    ) u_pwm (
        .clk    (clk),
        .rst    (rst),
        .pwm_on (w_pwm_on)
    );

    // Input stage: current and previous sampled code plus the wrap strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_code_q <= '0;
            r_code_p <= '0;
            r_gene_q <= 1'b0;
        end else begin
            r_code_q <= {bus.a2, bus.a1, bus.a0};
            r_code_p <= r_code_q;
            r_gene_q <= bus.gene;
        end
    end

    // Classify the latest transition; 6 has no in-range successor except via wrap.
    always_comb begin
        w_hold        = 1'b0;
        w_step        = 1'b0;
        w_wrap        = 1'b0;
        w_legal       = 1'b0;
        w_lock_req    = 1'b0;
        w_locked_next = 1'b0;

        w_hold     = !r_gene_q && (r_code_q == r_code_p) && (r_code_q != CODE_ILLEGAL);
        w_step     = !r_gene_q && (r_code_p < CODE_MAX)
                     && (r_code_q == CODE_W'(r_code_p + CODE_W'(1)));
        w_wrap     = r_gene_q && (r_code_p == CODE_MAX) && (r_code_q == '0);
        w_legal    = w_hold || w_step || w_wrap;
        w_lock_req = r_gene_q && (r_code_q == '0);

        if (r_state == SEARCH) begin
            w_locked_next = w_lock_req;
        end else begin
            w_locked_next = w_legal;
        end
    end

    // Sequence FSM with registered lock/error outputs and saturating error count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= SEARCH;
            r_locked  <= 1'b0;
            r_seq_err <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_seq_err <= 1'b0;
            case (r_state)
                SEARCH: begin
                    if (w_lock_req) begin
                        r_state  <= LOCKED;
                        r_locked <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (!w_legal) begin
                        r_state   <= SEARCH;
                        r_locked  <= 1'b0;
                        r_seq_err <= 1'b1;
                        if (r_err_cnt != ERR_MAX) begin
                            r_err_cnt <= r_err_cnt + ERR_W'(1);
                        end
                    end
                end
                default: begin
                    r_state  <= SEARCH;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    // Lamp register: colour gated by the lock decision of this edge and PWM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= colour_of(r_code_q) & {3{w_locked_next & w_pwm_on}};
        end
    end

    assign bus.led_r   = r_rgb[2];
    assign bus.led_g   = r_rgb[1];
    assign bus.led_b   = r_rgb[0];
    assign bus.locked  = r_locked;
    assign bus.seq_err = r_seq_err;
    assign bus.err_cnt = r_err_cnt;

endmodule

// File: tb/tb_count7_decoder.sv
// Bench for count7_decoder: directed table, saturation, PWM, async reset, random.
module tb_count7_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] code = 3'd0;
    logic       gene = 1'b0;

    always #5 clk = ~clk;

    count7_decoder_if                if0 ();
    count7_decoder_if #(.ERR_W(2))   if1 ();
    count7_decoder_if                if2 ();

    assign if0.gene = gene; assign if0.a0 = code[0]; assign if0.a1 = code[1]; assign if0.a2 = code[2];
    assign if1.gene = gene; assign if1.a0 = code[0]; assign if1.a1 = code[1]; assign if1.a2 = code[2];
    assign if2.gene = gene; assign if2.a0 = code[0]; assign if2.a1 = code[1]; assign if2.a2 = code[2];

    count7_decoder #(.PWM_BITS(4), .DUTY(16), .ERR_W(8)) u0 (.clk(clk), .rst(rst), .bus(if0));
    count7_decoder #(.PWM_BITS(4), .DUTY(4),  .ERR_W(2)) u1 (.clk(clk), .rst(rst), .bus(if1));
    count7_decoder #(.PWM_BITS(4), .DUTY(0),  .ERR_W(8)) u2 (.clk(clk), .rst(rst), .bus(if2));

    int n_tests = 0;
    int n_fail  = 0;
    int u1_pulses = 0;

    // Reference model state: last two samples, lock flag, raw violation count.
    int m_cq, m_cp;
    bit m_gq;
    bit m_locked;
    int m_errs;
    bit e_seq;
    int e_rgb;

    typedef struct {
        int code;
        bit gene;
        bit locked;
        bit seq;
        int err;
        int rgb;
    } vec_t;

    vec_t vecs[31];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Legal transitions of a mod-7 counter with a wrap strobe.
    function automatic bit legal_event(input int prev, input int cur, input bit g);
        if (cur > 6) return 1'b0;
        if (g) return (prev == 6) && (cur == 0);
        return (cur == prev) || (cur == prev + 1);
    endfunction

    task automatic model_reset();
        m_cq = 0; m_cp = 0; m_gq = 1'b0;
        m_locked = 1'b0; m_errs = 0; e_seq = 1'b0; e_rgb = 0;
    endtask

    task automatic model_edge();
        e_seq = 1'b0;
        if (!m_locked) begin
            if (m_gq && m_cq == 0) m_locked = 1'b1;
        end else if (!legal_event(m_cp, m_cq, m_gq)) begin
            m_locked = 1'b0;
            e_seq    = 1'b1;
            m_errs++;
        end
        e_rgb = m_locked ? ((m_cq + 1) % 8) : 0;
        m_cp = m_cq;
        m_cq = int'(code);
        m_gq = gene;
    endtask

    task automatic check_outputs();
        check("u0_locked",  int'(if0.locked),  int'(m_locked));
        check("u0_seq_err", int'(if0.seq_err), int'(e_seq));
        check("u0_err_cnt", int'(if0.err_cnt), min_i(m_errs, 255));
        check("u0_rgb",     int'({if0.led_r, if0.led_g, if0.led_b}), e_rgb);
        check("u1_locked",  int'(if1.locked),  int'(m_locked));
        check("u1_seq_err", int'(if1.seq_err), int'(e_seq));
        check("u1_err_cnt", int'(if1.err_cnt), min_i(m_errs, 3));
        if (!m_locked)
            check("u1_rgb_off", int'({if1.led_r, if1.led_g, if1.led_b}), 0);
        check("u2_locked",  int'(if2.locked), int'(m_locked));
        check("u2_rgb",     int'({if2.led_r, if2.led_g, if2.led_b}), 0);
        if (if1.seq_err) u1_pulses++;
    endtask

    // Drive at the falling edge, sample 1 ns after the rising edge.
    task automatic step(input int c, input bit g);
        code = 3'(c);
        gene = g;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_u0"}, int'({if0.led_r, if0.led_g, if0.led_b, if0.locked, if0.seq_err}), 0);
        check({tag, "_u0_err"}, int'(if0.err_cnt), 0);
        check({tag, "_u1"}, int'({if1.led_r, if1.led_g, if1.led_b, if1.locked, if1.seq_err}), 0);
        check({tag, "_u1_err"}, int'(if1.err_cnt), 0);
        check({tag, "_u2"}, int'({if2.led_r, if2.led_g, if2.led_b, if2.locked, if2.seq_err}), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_r, cnt_g, cnt_b;
        int cur;

        // Outputs reflect the sample taken one edge earlier, hence the row offset.
        vecs[0]  = '{0, 1, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 1, 0, 0, 1};
        vecs[2]  = '{2, 0, 1, 0, 0, 2};
        vecs[3]  = '{3, 0, 1, 0, 0, 3};
        vecs[4]  = '{4, 0, 1, 0, 0, 4};
        vecs[5]  = '{5, 0, 1, 0, 0, 5};
        vecs[6]  = '{6, 0, 1, 0, 0, 6};
        vecs[7]  = '{0, 1, 1, 0, 0, 7};
        vecs[8]  = '{1, 0, 1, 0, 0, 1};
        vecs[9]  = '{2, 0, 1, 0, 0, 2};
        vecs[10] = '{4, 0, 1, 0, 0, 3};
        vecs[11] = '{5, 0, 0, 1, 1, 0};
        vecs[12] = '{0, 1, 0, 0, 1, 0};
        vecs[13] = '{1, 0, 1, 0, 1, 1};
        vecs[14] = '{2, 0, 1, 0, 1, 2};
        vecs[15] = '{3, 1, 1, 0, 1, 3};
        vecs[16] = '{4, 0, 0, 1, 2, 0};
        vecs[17] = '{0, 1, 0, 0, 2, 0};
        vecs[18] = '{1, 0, 1, 0, 2, 1};
        vecs[19] = '{2, 0, 1, 0, 2, 2};
        vecs[20] = '{3, 0, 1, 0, 2, 3};
        vecs[21] = '{4, 0, 1, 0, 2, 4};
        vecs[22] = '{5, 0, 1, 0, 2, 5};
        vecs[23] = '{6, 0, 1, 0, 2, 6};
        vecs[24] = '{0, 0, 1, 0, 2, 7};
        vecs[25] = '{0, 0, 0, 1, 3, 0};
        vecs[26] = '{7, 0, 0, 0, 3, 0};
        vecs[27] = '{0, 1, 0, 0, 3, 0};
        vecs[28] = '{7, 0, 1, 0, 3, 1};
        vecs[29] = '{7, 0, 0, 1, 4, 0};
        vecs[30] = '{0, 0, 0, 0, 4, 0};

        // Power-on reset.
        model_reset();
        #1000;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Directed table: lock, colour cycle, skip, misplaced gene, missing gene, code 7.
        for (int i = 0; i < 31; i++) begin
            step(vecs[i].code, vecs[i].gene);
            check($sformatf("vec%0d_locked", i), int'(if0.locked), int'(vecs[i].locked));
            check($sformatf("vec%0d_seq", i), int'(if0.seq_err), int'(vecs[i].seq));
            check($sformatf("vec%0d_err", i), int'(if0.err_cnt), vecs[i].err);
            check($sformatf("vec%0d_rgb", i), int'({if0.led_r, if0.led_g, if0.led_b}), vecs[i].rgb);
        end

        // Fifth violation: narrow counter stays saturated but still pulses.
        step(0, 1);
        step(1, 0);
        step(3, 0);
        step(0, 0);
        check("sat_u1_seq", int'(if1.seq_err), 1);
        check("sat_u1_err", int'(if1.err_cnt), 3);
        check("sat_u1_pulses", u1_pulses, 5);
        check("sat_u0_err", int'(if0.err_cnt), 5);

        // PWM: lock, hold code 6 and count lamp-on cycles per 16-cycle period.
        step(0, 1);
        for (int c = 1; c <= 6; c++) step(c, 1'b0);
        for (int i = 0; i < 4; i++) step(6, 1'b0);
        for (int w = 0; w < 2; w++) begin
            cnt_r = 0; cnt_g = 0; cnt_b = 0;
            for (int i = 0; i < 16; i++) begin
                step(6, 1'b0);
                cnt_r += int'(if1.led_r);
                cnt_g += int'(if1.led_g);
                cnt_b += int'(if1.led_b);
            end
            check($sformatf("pwm4_r_w%0d", w), cnt_r, 4);
            check($sformatf("pwm4_g_w%0d", w), cnt_g, 4);
            check($sformatf("pwm4_b_w%0d", w), cnt_b, 4);
        end
        check("pwm16_white", int'({if0.led_r, if0.led_g, if0.led_b}), 7);
        check("pwm0_dark", int'({if2.led_r, if2.led_g, if2.led_b}), 0);

        // Async reset while locked, between clock edges.
        step(0, 1);
        step(1, 0);
        step(2, 0);
        step(3, 0);
        check("pre_reset_locked", int'(if0.locked), 1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(3, 0);
        step(4, 0);
        step(5, 0);
        check("post_reset_unlocked", int'(if0.locked), 0);
        step(0, 1);
        step(1, 0);
        check("post_reset_relock", int'(if0.locked), 1);

        // Random traffic, mostly legal with occasional arbitrary samples.
        cur = 1;
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit g;
            r = int'($urandom_range(0, 99));
            if (r < 85) begin
                if (cur <= 6 && $urandom_range(0, 3) == 0) begin
                    g = 1'b0;
                end else if (cur >= 6) begin
                    cur = 0;
                    g   = (r < 84);
                end else begin
                    cur = cur + 1;
                    g   = 1'b0;
                end
            end else begin
                cur = int'($urandom_range(0, 7));
                g   = 1'($urandom_range(0, 1));
            end
            step(cur, g);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
